// File: rtl/mul_pkg.sv
// Shared types and default sizes for the multiplier job sequencer and its integration.
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int MUL_W     = 16;
  localparam int MUL_TAG_W = 4;
  localparam int MUL_CNT_W = 16;

endpackage

// File: rtl/mul_job_sequencer.sv
// Control stage in front of system_multiplier: loads operands, pulses the result
// enable for one cycle, then presents the registered product with its tag.
module mul_job_sequencer
  import mul_pkg::*;
#(
  parameter int W     = MUL_W,
  parameter int TAG_W = MUL_TAG_W,
  parameter int CNT_W = MUL_CNT_W
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic [W-1:0]     mul_d_a,
  output logic [W-1:0]     mul_d_b,
  output logic             mul_en_a,
  output logic             mul_en_b,
  output logic             mul_en_result,
  input  logic [2*W-1:0]   mul_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*W-1:0]   out_product,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy,
  output logic [CNT_W-1:0] job_count
);

  // Both streams: a transfer happens on the rising edge where valid & ready are
  // both high; a source holding valid high must keep its data stable until then.

  state_t state_q;
  state_t state_d;
  logic   accept;
  logic   out_fire;

  // A new pair may enter while the previous product leaves in the same cycle.
  assign in_ready = (state_q == IDLE) | ((state_q == RESP) & out_ready);
  assign accept   = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  assign mul_d_a  = in_a;
  assign mul_d_b  = in_b;
  assign mul_en_a = accept;
  assign mul_en_b = accept;

  assign out_valid   = (state_q == RESP);
  assign out_product = mul_result;
  assign busy        = (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    mul_en_result = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) state_d = CALC;
      end
      CALC: begin
        mul_en_result = 1'b1;
        state_d       = RESP;
      end
      RESP: begin
        if (out_ready) state_d = accept ? CALC : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      out_tag <= '0;
    end else if (accept) begin
      out_tag <= in_tag;
    end
  end

  // Free-running wrap is intended: the counter is a modulo event count.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      job_count <= '0;
    end else if (out_fire) begin
      job_count <= job_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mul_job_sequencer.sv
// Self-checking bench: sequencer plus a behavioural system_multiplier, checked
// against a FIFO of products computed directly from the operands.
module tb_mul_job_sequencer;

  localparam int W     = 16;
  localparam int TAG_W = 4;
  localparam int CNT_W = 8;
  localparam int P     = 2 * W;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [W-1:0]     in_a = '0;
  logic [W-1:0]     in_b = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic [W-1:0]     mul_d_a;
  logic [W-1:0]     mul_d_b;
  logic             mul_en_a;
  logic             mul_en_b;
  logic             mul_en_result;
  logic [P-1:0]     mul_result;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [P-1:0]     out_product;
  logic [TAG_W-1:0] out_tag;
  logic             busy;
  logic [CNT_W-1:0] job_count;

  int vectors = 0;
  int miscompares = 0;
  logic [CNT_W-1:0] cnt_exp = '0;
  logic [P+TAG_W-1:0] exp_q[$];

  always #5 clk = ~clk;

  mul_job_sequencer #(.W(W), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .mul_d_a(mul_d_a), .mul_d_b(mul_d_b),
    .mul_en_a(mul_en_a), .mul_en_b(mul_en_b), .mul_en_result(mul_en_result),
    .mul_result(mul_result),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_product(out_product), .out_tag(out_tag),
    .busy(busy), .job_count(job_count)
  );

  // Behavioural system_multiplier: enabled operand registers, registered product.
  logic [W-1:0] ra, rb;
  always_ff @(posedge clk) begin
    if (!rstn) begin
      ra <= '0;
      rb <= '0;
      mul_result <= '0;
    end else begin
      if (mul_en_a) ra <= mul_d_a;
      if (mul_en_b) rb <= mul_d_b;
      if (mul_en_result) mul_result <= P'(ra) * P'(rb);
    end
  end

  // Drive one cycle's inputs on the falling edge and let combinational outputs settle.
  task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [TAG_W-1:0] t, input logic ordy);
    @(negedge clk);
    in_valid = v; in_a = a; in_b = b; in_tag = t; out_ready = ordy;
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    drive(1'b0, '0, '0, '0, 1'b0);
    drive(1'b0, '0, '0, '0, 1'b0);
    vectors++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_ctrl: out_valid=%b busy=%b in_ready=%b want 0 0 1", out_valid, busy, in_ready);
    end
    vectors++;
    if (out_tag !== '0 || job_count !== '0) begin
      miscompares++;
      $display("FAIL reset_regs: out_tag=%0h job_count=%0h want 0 0", out_tag, job_count);
    end
    vectors++;
    if (mul_en_a !== 1'b0 || mul_en_b !== 1'b0 || mul_en_result !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_en: en_a=%b en_b=%b en_result=%b want 0 0 0", mul_en_a, mul_en_b, mul_en_result);
    end
    rstn = 1'b1;
    cnt_exp = '0;
  endtask

  task automatic test_basic();
    drive(1'b1, 16'd3, 16'd4, 4'd5, 1'b1);
    vectors++;
    if (in_ready !== 1'b1 || mul_en_a !== 1'b1 || mul_en_b !== 1'b1 || mul_d_a !== 16'd3 || mul_d_b !== 16'd4) begin
      miscompares++;
      $display("FAIL basic_accept: in_ready=%b en_a=%b en_b=%b d_a=%0h d_b=%0h want 1 1 1 3 4",
               in_ready, mul_en_a, mul_en_b, mul_d_a, mul_d_b);
    end
    drive(1'b0, '0, '0, '0, 1'b1);
    vectors++;
    if (mul_en_result !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b1 || mul_en_a !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_calc: en_result=%b out_valid=%b busy=%b en_a=%b want 1 0 1 0",
               mul_en_result, out_valid, busy, mul_en_a);
    end
    drive(1'b0, '0, '0, '0, 1'b1);
    vectors++;
    if (out_valid !== 1'b1 || out_product !== 32'd12 || out_tag !== 4'd5 || mul_en_result !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_resp: out_valid=%b product=%0h tag=%0h en_result=%b want 1 c 5 0",
               out_valid, out_product, out_tag, mul_en_result);
    end
    cnt_exp++;
    drive(1'b0, '0, '0, '0, 1'b0);
    vectors++;
    if (job_count !== cnt_exp || out_valid !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_done: job_count=%0h out_valid=%b busy=%b want %0h 0 0", job_count, out_valid, busy, cnt_exp);
    end
  endtask

  task automatic test_hold();
    drive(1'b1, 16'hFFFF, 16'hFFFF, 4'hA, 1'b0);
    drive(1'b0, '0, '0, '0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, '0, '0, '0, 1'b0);
      vectors++;
      if (out_valid !== 1'b1 || out_product !== 32'hFFFE0001 || out_tag !== 4'hA || in_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL hold_%0d: out_valid=%b product=%0h tag=%0h in_ready=%b want 1 fffe0001 a 0",
                 i, out_valid, out_product, out_tag, in_ready);
      end
    end
    drive(1'b0, '0, '0, '0, 1'b1);
    cnt_exp++;
    drive(1'b0, '0, '0, '0, 1'b0);
    vectors++;
    if (job_count !== cnt_exp || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL hold_release: job_count=%0h out_valid=%b want %0h 0", job_count, out_valid, cnt_exp);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] pa[3];
    logic [W-1:0] pb[3];
    logic [P+TAG_W-1:0] e;
    int idx = 0;
    int nout = 0;
    int last = 0;
    pa = '{16'd2, 16'd0, 16'd7};
    pb = '{16'd3, 16'd9, 16'd8};
    for (int cyc = 0; cyc < 20 && !(idx == 3 && exp_q.size() == 0); cyc++) begin
      drive(idx < 3, pa[idx % 3], pb[idx % 3], TAG_W'(idx + 1), 1'b1);
      if (out_valid && out_ready) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL b2b_extra: product=%0h with nothing expected", out_product);
        end else begin
          e = exp_q.pop_front();
          if ({out_product, out_tag} !== e || (nout > 0 && cyc - last != 2)) begin
            miscompares++;
            $display("FAIL b2b_out_%0d: product=%0h tag=%0h gap=%0d want %0h %0h gap 2",
                     nout, out_product, out_tag, cyc - last, e[P+TAG_W-1:TAG_W], e[TAG_W-1:0]);
          end
        end
        nout++;
        last = cyc;
        cnt_exp++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back({P'(pa[idx]) * P'(pb[idx]), TAG_W'(idx + 1)});
        idx++;
      end
    end
    drive(1'b0, '0, '0, '0, 1'b0);
    vectors++;
    if (nout != 3 || job_count !== cnt_exp) begin
      miscompares++;
      $display("FAIL b2b_count: outputs=%0d job_count=%0h want 3 %0h", nout, job_count, cnt_exp);
    end
    exp_q.delete();
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 16'd5, 16'd6, 4'd2, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    rstn = 1'b0;
    #1;
    vectors++;
    if (mul_en_result !== 1'b1) begin
      miscompares++;
      $display("FAIL rstmid_calc: en_result=%b want 1", mul_en_result);
    end
    @(negedge clk);
    rstn = 1'b1;
    #1;
    cnt_exp = '0;
    vectors++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || job_count !== '0) begin
      miscompares++;
      $display("FAIL rstmid_idle: busy=%b out_valid=%b job_count=%0h want 0 0 0", busy, out_valid, job_count);
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, '0, '0, '0, 1'b1);
      vectors++;
      if (out_valid !== 1'b0 || job_count !== '0) begin
        miscompares++;
        $display("FAIL rstmid_drop_%0d: out_valid=%b job_count=%0h want 0 0", i, out_valid, job_count);
      end
    end
  endtask

  task automatic test_wrap();
    localparam int N = (1 << CNT_W) - 1;
    int acc = 0;
    int outs = 0;
    logic [W-1:0] a = W'($urandom);
    logic [W-1:0] b = W'($urandom);
    for (int cyc = 0; cyc < 4 * N && outs < N; cyc++) begin
      drive(acc < N, a, b, TAG_W'(acc), 1'b1);
      if (out_valid && out_ready) begin
        outs++;
        cnt_exp++;
      end
      if (in_valid && in_ready) begin
        acc++;
        a = W'($urandom);
        b = W'($urandom);
      end
    end
    drive(1'b0, '0, '0, '0, 1'b1);
    vectors++;
    if (outs != N || job_count !== {CNT_W{1'b1}}) begin
      miscompares++;
      $display("FAIL wrap_full: outputs=%0d job_count=%0h want %0d %0h", outs, job_count, N, {CNT_W{1'b1}});
    end
    drive(1'b1, 16'd1, 16'd1, 4'd0, 1'b1);
    drive(1'b0, '0, '0, '0, 1'b1);
    drive(1'b0, '0, '0, '0, 1'b1);
    cnt_exp++;
    drive(1'b0, '0, '0, '0, 1'b0);
    vectors++;
    if (job_count !== '0 || cnt_exp !== '0) begin
      miscompares++;
      $display("FAIL wrap_zero: job_count=%0h want 0", job_count);
    end
  endtask

  task automatic test_random();
    localparam int JOBS = 10000;
    logic pend = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [TAG_W-1:0] t = '0;
    logic hold_prev = 1'b0;
    logic [P-1:0] prev_p = '0;
    logic [TAG_W-1:0] prev_t = '0;
    logic [P+TAG_W-1:0] e;
    int acc = 0;
    int outs = 0;
    int en_cnt = 0;
    for (int cyc = 0; cyc < 70000 && outs < JOBS; cyc++) begin
      if (!pend && acc < JOBS && $urandom_range(0, 9) < 7) begin
        pend = 1'b1;
        a = W'($urandom);
        b = W'($urandom);
        t = TAG_W'($urandom);
      end
      drive(pend, a, b, t, $urandom_range(0, 9) < 7);
      if (mul_en_result) en_cnt++;
      vectors++;
      if (job_count !== cnt_exp) begin
        miscompares++;
        $display("FAIL rand_count: cycle %0d job_count=%0h want %0h", cyc, job_count, cnt_exp);
      end
      if (hold_prev) begin
        vectors++;
        if (out_valid !== 1'b1 || out_product !== prev_p || out_tag !== prev_t) begin
          miscompares++;
          $display("FAIL rand_stable: out_valid=%b product=%0h tag=%0h want 1 %0h %0h",
                   out_valid, out_product, out_tag, prev_p, prev_t);
        end
      end
      if (out_valid && out_ready) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL rand_extra: product=%0h with nothing expected", out_product);
        end else begin
          e = exp_q.pop_front();
          if ({out_product, out_tag} !== e) begin
            miscompares++;
            $display("FAIL rand_out_%0d: product=%0h tag=%0h want %0h %0h",
                     outs, out_product, out_tag, e[P+TAG_W-1:TAG_W], e[TAG_W-1:0]);
          end
        end
        outs++;
        cnt_exp++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back({P'(a) * P'(b), t});
        acc++;
        pend = 1'b0;
      end
      hold_prev = out_valid && !out_ready;
      prev_p = out_product;
      prev_t = out_tag;
    end
    drive(1'b0, '0, '0, '0, 1'b0);
    vectors++;
    if (outs != JOBS || acc != JOBS || en_cnt != acc || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL rand_totals: outputs=%0d accepted=%0d en_result_pulses=%0d left=%0d want %0d each, 0 left",
               outs, acc, en_cnt, exp_q.size(), JOBS);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
